// File: rtl/soc_uart_pkg.sv
// rtl/soc_uart_pkg.sv - shared constants and state encoding for the UART transmit path
package soc_uart_pkg;

  localparam int UART_DW = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_XFER = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_XFER = ST_XFER
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder, first request at or after ptr
module rr_pick
  import soc_uart_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/soc_uart_tx_arbiter.sv
// rtl/soc_uart_tx_arbiter.sv - message-locked round-robin arbiter in front of the UART serializer
module soc_uart_tx_arbiter
  import soc_uart_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DW        = UART_DW,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic               tx_valid,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_ready,
  output logic [NREQ-1:0]    grant,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic [PW-1:0]   own;
  logic            xfer;
  logic            burst_hit;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  always_comb begin
    own = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) own = PW'(i);
    end
  end

  // Pure pass-through from the owner; tx_ready only reaches req_ready, never tx_valid.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state_q == S_XFER) begin
      tx_valid       = req_valid[own];
      tx_data        = req_data[int'(own)*DW +: DW];
      req_ready[own] = tx_ready;
    end
  end

  assign xfer      = tx_valid && tx_ready;
  assign burst_hit = (MAX_BURST != 0) && (({1'b0, cnt_q} + 1'b1) == (CW+1)'(MAX_BURST));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_XFER;
          grant_d = pick_gnt;
          cnt_d   = '0;
        end
      end
      S_XFER: begin
        if (xfer) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (req_last[own] || burst_hit) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = (own == PW'(NREQ - 1)) ? '0 : own + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == S_XFER);

endmodule

// File: tb/tb_soc_uart_tx_arbiter.sv
// tb/tb_soc_uart_tx_arbiter.sv - self-checking bench for soc_uart_tx_arbiter
module tb_soc_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam logic [1:0] GE_FR [12] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                         2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01};

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rv, rl, rdy, gnt;
  logic [15:0] rd;
  logic        txr, txv, busy;
  logic [7:0]  txd;

  always #5 clk = ~clk;

  soc_uart_tx_arbiter #(.NREQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (rv),
    .req_data  (rd),
    .req_last  (rl),
    .req_ready (rdy),
    .tx_valid  (txv),
    .tx_data   (txd),
    .tx_ready  (txr),
    .grant     (gnt),
    .busy      (busy)
  );

  typedef struct packed {logic [7:0] d; logic l;} item_t;
  typedef struct {
    logic rst; logic [1:0] rv; logic [15:0] rd; logic [1:0] rl; logic txr;
    logic [1:0] g; logic v; logic [7:0] d; logic [1:0] r; logic b;
  } vec_t;

  item_t       srcq [N][$];
  logic [1:0]  stall;
  logic [9:0]  dlog[$];
  logic [9:0]  exp_q[$];
  logic [1:0]  glog[$];
  vec_t        tv[$];
  int          m_owner, m_ptr, m_cnt;
  int          n_chk, n_err;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: owner index (-1 when idle), scan pointer and byte count as plain integers.
  task automatic check_model();
    logic [1:0] e_g, e_r;
    logic       e_v, e_b;
    logic [7:0] e_d;
    e_g = 2'b00; e_r = 2'b00; e_v = 1'b0; e_d = 8'h00; e_b = (m_owner >= 0);
    if (e_b) begin
      e_g = 2'(1 << m_owner);
      e_v = rv[m_owner];
      e_d = rd[m_owner*8 +: 8];
      e_r = txr ? e_g : 2'b00;
    end
    chk("grant", gnt, e_g);
    chk("tx_valid", txv, e_v);
    chk("tx_data", txd, e_d);
    chk("req_ready", rdy, e_r);
    chk("busy", busy, e_b);
    glog.push_back(gnt);
    if (!reset && txv && txr) dlog.push_back({gnt, txd});
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_owner < 0 && rv[i]) begin
          m_owner = i;
          m_cnt   = 0;
        end
      end
    end else if (rv[m_owner] && txr) begin
      if (srcq[m_owner].size() > 0) void'(srcq[m_owner].pop_front());
      m_cnt++;
      if (rl[m_owner] || m_cnt == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    advance();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && !stall[i]) begin
        rv[i]        = 1'b1;
        rd[i*8 +: 8] = srcq[i][0].d;
        rl[i]        = srcq[i][0].l;
      end else begin
        rv[i]        = 1'b0;
        rd[i*8 +: 8] = 8'($urandom);
        rl[i]        = 1'($urandom);
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      drive_inputs();
      step();
    end
  endtask

  task automatic push_msg(int i, logic [7:0] base, int len, logic last);
    for (int b = 0; b < len; b++) srcq[i].push_back({8'(base + 8'(b)), last && (b == len - 1)});
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 2'b00; rv = 2'b00; rl = 2'b00; rd = 16'h0; txr = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    step();
    reset = 1'b0;
    dlog.delete(); glog.delete(); exp_q.delete();
  endtask

  task automatic chk_dlog(string nm);
    chk({nm, "_count"}, dlog.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < dlog.size()) chk(nm, dlog[k], exp_q[k]);
    end
  endtask

  task automatic add(logic rst, logic [1:0] v_rv, logic [15:0] v_rd, logic [1:0] v_rl, logic v_txr,
                     logic [1:0] g, logic v, logic [7:0] d, logic [1:0] r, logic b);
    tv.push_back('{rst, v_rv, v_rd, v_rl, v_txr, g, v, d, r, b});
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    stall = 2'b00; rv = 2'b00; rl = 2'b00; rd = 16'h0; txr = 1'b1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    add(1, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    add(0, 2'b01, 16'h00A1, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    add(0, 2'b01, 16'h00A1, 2'b00, 1, 2'b01, 1, 8'hA1, 2'b01, 1);
    add(0, 2'b01, 16'h00A2, 2'b00, 1, 2'b01, 1, 8'hA2, 2'b01, 1);
    add(0, 2'b01, 16'h00A3, 2'b01, 1, 2'b01, 1, 8'hA3, 2'b01, 1);
    add(0, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    add(1, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    add(0, 2'b11, 16'h2010, 2'b11, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    add(0, 2'b11, 16'h2010, 2'b11, 1, 2'b01, 1, 8'h10, 2'b01, 1);
    add(0, 2'b10, 16'h2010, 2'b11, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 16'h2010, 2'b10, 1, 2'b10, 1, 8'h20, 2'b10, 1);
    add(0, 2'b11, 16'h2212, 2'b11, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    add(0, 2'b11, 16'h2212, 2'b11, 1, 2'b01, 1, 8'h12, 2'b01, 1);
    add(0, 2'b10, 16'h2212, 2'b10, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 16'h2212, 2'b10, 1, 2'b10, 1, 8'h22, 2'b10, 1);
    add(0, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 16'h5500, 2'b10, 0, 2'b00, 0, 8'h00, 2'b00, 0);
    repeat (5) add(0, 2'b10, 16'h5500, 2'b10, 0, 2'b10, 1, 8'h55, 2'b00, 1);
    add(0, 2'b10, 16'h5500, 2'b10, 1, 2'b10, 1, 8'h55, 2'b10, 1);
    add(0, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);

    foreach (tv[k]) begin
      reset = tv[k].rst; rv = tv[k].rv; rd = tv[k].rd; rl = tv[k].rl; txr = tv[k].txr;
      @(negedge clk);
      chk("tv_grant", gnt, tv[k].g);
      chk("tv_tx_valid", txv, tv[k].v);
      chk("tv_tx_data", txd, tv[k].d);
      chk("tv_req_ready", rdy, tv[k].r);
      chk("tv_busy", busy, tv[k].b);
      check_model();
      advance();
    end
    begin
      int n55;
      n55 = 0;
      foreach (dlog[k]) if (dlog[k] == {2'b10, 8'h55}) n55++;
      chk("backpressure_transfers", n55, 1);
    end

    // Forced release after MB bytes with the other requester waiting.
    do_reset();
    push_msg(0, 8'h30, 6, 1'b0);
    push_msg(1, 8'h40, 2, 1'b1);
    run(12);
    foreach (GE_FR[k]) chk("forced_grant_seq", glog[k], GE_FR[k]);
    exp_q = '{{2'b01, 8'h30}, {2'b01, 8'h31}, {2'b01, 8'h32}, {2'b01, 8'h33},
              {2'b10, 8'h40}, {2'b10, 8'h41}, {2'b01, 8'h34}, {2'b01, 8'h35}};
    chk_dlog("forced_order");

    // Reset in the middle of a message.
    do_reset();
    push_msg(1, 8'h50, 4, 1'b1);
    run(3);
    reset = 1'b1;
    drive_inputs();
    step();
    for (int i = 0; i < N; i++) srcq[i].delete();
    reset = 1'b0;
    drive_inputs();
    @(negedge clk);
    chk("midrst_grant", gnt, 2'b00);
    chk("midrst_tx_valid", txv, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    check_model();
    advance();
    push_msg(1, 8'h5A, 1, 1'b1);
    run(3);
    exp_q = '{{2'b10, 8'h50}, {2'b10, 8'h51}, {2'b10, 8'h5A}};
    chk_dlog("midrst_order");

    // Owner stalls mid-message while the other requester waits.
    do_reset();
    push_msg(0, 8'h60, 3, 1'b1);
    push_msg(1, 8'h70, 1, 1'b1);
    run(2);
    stall = 2'b01;
    repeat (3) begin
      drive_inputs();
      @(negedge clk);
      chk("stall_grant", gnt, 2'b01);
      chk("stall_tx_valid", txv, 1'b0);
      check_model();
      advance();
    end
    stall = 2'b00;
    run(6);
    exp_q = '{{2'b01, 8'h60}, {2'b01, 8'h61}, {2'b01, 8'h62}, {2'b10, 8'h70}};
    chk_dlog("stall_order");

    // Random traffic against the reference.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5) == 0) begin
        int i;
        i = int'($urandom_range(N - 1));
        if (srcq[i].size() < 8)
          push_msg(i, 8'($urandom), int'($urandom_range(6, 1)), $urandom_range(4) != 0);
      end
      for (int i = 0; i < N; i++) stall[i] = ($urandom_range(7) == 0);
      txr = ($urandom_range(3) != 0);
      drive_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/soc_uart_tx_arbiter.md
# soc_uart_tx_arbiter

Round-robin, message-locked arbiter that shares the SoC's single UART transmit serializer (the path driving `ser_tx`) between several byte-stream requesters, such as the CPU console port and the AI-engine debug/result port. It sits between the requesters and the serializer's valid/ready byte input. It grants one requester at a time and holds the grant until that requester's message ends, so bytes from different sources never interleave on the serial line.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (≥2).
- `DW`, 8: byte width.
- `MAX_BURST`, 16: forced-release limit in bytes per grant. 0 means unlimited.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_data`  in  NREQ*DW  per-requester byte. Requester i uses bits [i*DW +: DW].
- `req_last`  in  NREQ  marks the final byte of a message.
- `req_ready`  out  NREQ  per-requester accept.
- `tx_valid`  out  1  byte valid to the serializer.
- `tx_data`  out  DW  byte to the serializer.
- `tx_ready`  in  1  serializer accept.
- `grant`  out  NREQ  one-hot current owner. All zero when idle.
- `busy`  out  1  high while any grant is held.

## Operation
- States: IDLE and XFER.
- IDLE:
  - If any `req_valid` is high, pick the first requester at or after pointer `ptr`, scanning upward with wrap-around.
  - Register `grant`, clear `cnt`, and go to XFER on the next edge.
  - If no request is present, stay in IDLE.
- XFER with owner g:
  - Combinational pass-through: `tx_valid = req_valid[g]`, `tx_data = req_data[g]`, `req_ready[g] = tx_ready`.
  - All other `req_ready` bits are 0.
- A transfer is a cycle with `tx_valid && tx_ready`. Each transfer increments `cnt`.
- Release happens on a transfer when `req_last[g]` is high, or when `MAX_BURST != 0` and `cnt + 1 == MAX_BURST`. On release:
  - next state is IDLE,
  - `grant` is cleared,
  - `ptr` becomes (g+1) mod NREQ.
- The owner dropping `req_valid` mid-message does not release the grant. There is no timeout.
- `req_last` is ignored when no transfer occurs.
- In IDLE, all of `tx_valid`, `req_ready` and `grant` are 0.
- `cnt` width is clog2(MAX_BURST+1), minimum 1. It saturates when unlimited and never wraps into a false release.

## Timing
- Reset values: state IDLE, `ptr` 0, `cnt` 0, `grant` 0, `busy` 0, `tx_valid` 0, `req_ready` 0, `tx_data` 0.
- Reset applies mid-message. The grant drops on the edge after `reset` is sampled high, and the partial message is abandoned.
- Arbitration latency: the first byte can transfer in the cycle after `req_valid` is first seen in IDLE.
- After a release there is one idle (arbitration) cycle before the next grant. Per message, throughput is therefore at most 1 byte/cycle plus 1 cycle overhead.
- Backpressure: while `tx_ready` is low, `req_ready[g]` is low. The requester must hold its data stable; the block stores nothing.
- Simultaneous new requests in IDLE are resolved only by `ptr`. Requests arriving during XFER wait.
- No combinational path from `tx_ready` to `tx_valid`. `tx_ready` may depend on `tx_valid`.

## Structure
- Shared package `soc_uart_pkg` holds:
  - state encoding localparams `ST_IDLE` and `ST_XFER`,
  - the default byte width `UART_DW = 8`.
- One sub-module: `rr_pick`, a combinational round-robin priority encoder.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: one-hot `gnt` and `any`.
- All state lives in `soc_uart_tx_arbiter`.

## Test plan
- **Single message:**
  - Stimulus: requester 0 sends 0xA1, 0xA2, 0xA3 (last on 0xA3), with `tx_ready` held at 1.
  - Response: `grant` = 01 one cycle after `req_valid`. `tx_data` is A1, A2, A3 on consecutive cycles. `busy` falls the cycle after A3.
- **Simultaneous requests after reset:**
  - Stimulus: both requesters send one-byte messages 0x10 (req0) and 0x20 (req1). Then both request again.
  - Response: order on `tx_data` is 0x10, then 0x20. The second round goes to req0 again (`ptr` = 0 after req1).
- **Backpressure:**
  - Stimulus: hold `tx_ready` at 0 for 5 cycles during requester 1's byte 0x55.
  - Response: `tx_valid` = 1 and `tx_data` = 0x55 stable throughout. `req_ready[1]` = 0. Exactly one transfer occurs once `tx_ready` = 1.
- **Forced release:**
  - Stimulus: `MAX_BURST` = 4. Requester 0 streams 6 bytes with no `req_last`; requester 1 is waiting.
  - Response: after the 4th byte, `grant` goes to 00, then to 10. Requester 1's bytes follow, then requester 0 resumes.
- **Reset mid-message:**
  - Stimulus: assert `reset` after 2 of 4 bytes from requester 1.
  - Response: on the next edge, `grant`, `tx_valid` and `busy` are 0. After release, with only requester 1 requesting, it wins with `ptr` = 0 scanning.
- **Owner stall:**
  - Stimulus: requester 0 drops `req_valid` for 3 cycles mid-message while requester 1 requests.
  - Response: `grant` stays 01 and `tx_valid` = 0 during the gap. Requester 1 is not served until requester 0's last byte.
